// File: rtl/instr_fetch.sv
// Instruction fetch stage for the WISC-15 pipeline.
// Owns the PC and the IF/ID register. It also handles stall, flush/redirect, HLT and the fetch counter.
module instr_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [3:0]  HLT_OP    = 4'hF,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] br_tgt,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    input  logic [15:0] im_instr,
    output logic [15:0] pc,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcp1_q, pcp1_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp1_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp1_q  <= pcp1_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: flush > stall > HLT detect > normal advance. Reset is handled in the register process.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp1_d  = pcp1_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            pc_d    = br_tgt;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (stall) begin
            // hold everything
        end else if (state_q == RUN) begin
            instr_d = im_instr;
            pcp1_d  = pc_q + 16'd1;
            valid_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
            if (im_instr[15:12] == HLT_OP) begin
                state_d = HALTED;
            end else begin
                pc_d = pc_q + 16'd1;
            end
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    assign im_rd_en       = (state_q == RUN) & ~stall & ~rst;
    assign im_addr        = pc_q;
    assign pc             = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus1 = pcp1_q;
    assign if_id_valid    = valid_q;
    assign halted         = (state_q == HALTED);
    assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch, driven against a behavioural word-addressed memory.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [15:0] br_tgt;
    logic [15:0] im_addr, im_instr, pc, if_id_instr, if_id_pc_plus1, fetch_cnt;
    logic        im_rd_en, if_id_valid, halted;

    logic [15:0] mem [0:65535];
    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    assign im_instr = mem[im_addr];

    instr_fetch #(.RESET_PC(16'h0000), .HLT_OP(4'hF), .NOP_INSTR(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_tgt(br_tgt),
        .im_addr(im_addr), .im_rd_en(im_rd_en), .im_instr(im_instr), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc_plus1(if_id_pc_plus1),
        .if_id_valid(if_id_valid), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; br_tgt = '0;
        tick(); tick();
        tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h exp 0000", pc); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
        tests++; if (if_id_instr !== 16'h0000) begin fails++; $display("FAIL reset_instr got %h exp 0000", if_id_instr); end
        tests++; if (if_id_pc_plus1 !== 16'h0000) begin fails++; $display("FAIL reset_pcp1 got %h exp 0000", if_id_pc_plus1); end
        tests++; if (fetch_cnt !== 16'h0000) begin fails++; $display("FAIL reset_cnt got %h exp 0000", fetch_cnt); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
        tests++; if (im_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rden got %b exp 0", im_rd_en); end
        rst = 1'b0;
        #1;
        tests++; if (im_rd_en !== 1'b1) begin fails++; $display("FAIL post_reset_rden got %b exp 1", im_rd_en); end
    endtask

    task automatic test_sequential();
        logic [15:0] exp_w [0:2];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            tests++; if (im_rd_en !== 1'b1) begin fails++; $display("FAIL seq_rden[%0d] got %b exp 1", i, im_rd_en); end
            tick();
            tests++; if (if_id_instr !== exp_w[i]) begin fails++; $display("FAIL seq_instr[%0d] got %h exp %h", i, if_id_instr, exp_w[i]); end
            tests++; if (if_id_pc_plus1 !== 16'(i + 1)) begin fails++; $display("FAIL seq_pcp1[%0d] got %h exp %h", i, if_id_pc_plus1, 16'(i + 1)); end
            tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d] got %b exp 1", i, if_id_valid); end
        end
        tests++; if (fetch_cnt !== 16'd3) begin fails++; $display("FAIL seq_cnt got %0d exp 3", fetch_cnt); end
        tests++; if (pc !== 16'd3) begin fails++; $display("FAIL seq_pc got %h exp 0003", pc); end
    endtask

    task automatic test_stall();
        tick(); tick();
        tests++; if (pc !== 16'd5) begin fails++; $display("FAIL stall_pre_pc got %h exp 0005", pc); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (im_rd_en !== 1'b0) begin fails++; $display("FAIL stall_rden[%0d] got %b exp 0", i, im_rd_en); end
            tick();
            tests++; if (pc !== 16'd5) begin fails++; $display("FAIL stall_pc[%0d] got %h exp 0005", i, pc); end
            tests++; if (if_id_instr !== 16'h1004) begin fails++; $display("FAIL stall_instr[%0d] got %h exp 1004", i, if_id_instr); end
            tests++; if (if_id_pc_plus1 !== 16'd5) begin fails++; $display("FAIL stall_pcp1[%0d] got %h exp 0005", i, if_id_pc_plus1); end
            tests++; if (fetch_cnt !== 16'd5) begin fails++; $display("FAIL stall_cnt[%0d] got %0d exp 5", i, fetch_cnt); end
        end
        stall = 1'b0;
        tick();
        tests++; if (if_id_instr !== 16'h1005) begin fails++; $display("FAIL resume_instr got %h exp 1005", if_id_instr); end
        tests++; if (if_id_pc_plus1 !== 16'd6) begin fails++; $display("FAIL resume_pcp1 got %h exp 0006", if_id_pc_plus1); end
        tests++; if (fetch_cnt !== 16'd6) begin fails++; $display("FAIL resume_cnt got %0d exp 6", fetch_cnt); end
    endtask

    task automatic test_flush_over_stall();
        stall = 1'b1; flush = 1'b1; br_tgt = 16'h0040;
        tick();
        stall = 1'b0; flush = 1'b0;
        tests++; if (pc !== 16'h0040) begin fails++; $display("FAIL flush_pc got %h exp 0040", pc); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", if_id_valid); end
        tests++; if (if_id_instr !== 16'h0000) begin fails++; $display("FAIL flush_instr got %h exp 0000", if_id_instr); end
        tests++; if (fetch_cnt !== 16'd6) begin fails++; $display("FAIL flush_cnt got %0d exp 6", fetch_cnt); end
        tick();
        tests++; if (if_id_instr !== 16'h1040) begin fails++; $display("FAIL flush_fetch got %h exp 1040", if_id_instr); end
        tests++; if (if_id_pc_plus1 !== 16'h0041) begin fails++; $display("FAIL flush_pcp1 got %h exp 0041", if_id_pc_plus1); end
        tests++; if (fetch_cnt !== 16'd7) begin fails++; $display("FAIL flush_cnt2 got %0d exp 7", fetch_cnt); end
    endtask

    task automatic test_hlt();
        mem[3] = 16'hF000;
        flush = 1'b1; br_tgt = 16'h0003;
        tick();
        flush = 1'b0;
        tick();
        tests++; if (if_id_instr !== 16'hF000) begin fails++; $display("FAIL hlt_instr got %h exp f000", if_id_instr); end
        tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL hlt_valid got %b exp 1", if_id_valid); end
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL hlt_halted got %b exp 1", halted); end
        tests++; if (pc !== 16'h0003) begin fails++; $display("FAIL hlt_pc got %h exp 0003", pc); end
        tests++; if (im_rd_en !== 1'b0) begin fails++; $display("FAIL hlt_rden got %b exp 0", im_rd_en); end
        tests++; if (fetch_cnt !== 16'd8) begin fails++; $display("FAIL hlt_cnt got %0d exp 8", fetch_cnt); end
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tests++; if (if_id_instr !== 16'hF000 || if_id_valid !== 1'b1) begin fails++; $display("FAIL hlt_stall_hold got %h/%b exp f000/1", if_id_instr, if_id_valid); end
        tick();
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL hlt_bubble_valid got %b exp 0", if_id_valid); end
        tests++; if (if_id_instr !== 16'h0000) begin fails++; $display("FAIL hlt_bubble_instr got %h exp 0000", if_id_instr); end
        for (int i = 0; i < 4; i++) tick();
        tests++; if (halted !== 1'b1 || pc !== 16'h0003 || fetch_cnt !== 16'd8) begin fails++; $display("FAIL hlt_stay got halted=%b pc=%h cnt=%0d exp 1/0003/8", halted, pc, fetch_cnt); end
        flush = 1'b1; br_tgt = 16'h0010;
        tick();
        flush = 1'b0;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL hlt_unhalt got %b exp 0", halted); end
        tests++; if (pc !== 16'h0010) begin fails++; $display("FAIL hlt_redirect_pc got %h exp 0010", pc); end
        tick();
        tests++; if (if_id_instr !== 16'h1010) begin fails++; $display("FAIL hlt_resume_instr got %h exp 1010", if_id_instr); end
        tests++; if (fetch_cnt !== 16'd9) begin fails++; $display("FAIL hlt_resume_cnt got %0d exp 9", fetch_cnt); end
    endtask

    task automatic test_pc_wrap();
        flush = 1'b1; br_tgt = 16'hFFFF;
        tick();
        flush = 1'b0;
        tick();
        tests++; if (if_id_instr !== 16'h1FFF) begin fails++; $display("FAIL wrap_instr got %h exp 1fff", if_id_instr); end
        tests++; if (if_id_pc_plus1 !== 16'h0000) begin fails++; $display("FAIL wrap_pcp1 got %h exp 0000", if_id_pc_plus1); end
        tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL wrap_pc got %h exp 0000", pc); end
        tests++; if (fetch_cnt !== 16'd10) begin fails++; $display("FAIL wrap_cnt got %0d exp 10", fetch_cnt); end
    endtask

    task automatic test_reset_mid();
        flush = 1'b1; br_tgt = 16'h0003;
        tick();
        flush = 1'b0;
        tick();
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL rstmid_pre_halted got %b exp 1", halted); end
        stall = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL rstmid_pc got %h exp 0000", pc); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b exp 0", if_id_valid); end
        tests++; if (fetch_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_cnt got %0d exp 0", fetch_cnt); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rstmid_halted got %b exp 0", halted); end
    endtask

    task automatic test_saturation();
        mem[3] = 16'h1003;
        for (int i = 0; i < 65534; i++) tick();
        tests++; if (fetch_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_pre got %h exp fffe", fetch_cnt); end
        tick();
        tests++; if (fetch_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_max got %h exp ffff", fetch_cnt); end
        tick(); tick();
        tests++; if (fetch_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold got %h exp ffff", fetch_cnt); end
        tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL sat_valid got %b exp 1", if_id_valid); end
    endtask

    initial begin
        for (int unsigned a = 0; a < 65536; a++) mem[a] = {4'h1, a[11:0]};
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        test_reset();
        test_sequential();
        test_stall();
        test_flush_over_stall();
        test_hlt();
        test_pc_wrap();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Initiator side of the instruction-memory read interface for the WISC-15 pipeline.
- Owns the PC, drives im_addr/im_rd_en, and captures the returned word into the IF/ID pipeline register.
- Handles stall, branch redirect/flush, HLT detection and a retired-fetch counter.
- Sits between the instruction memory (word-addressed, 16-bit; latches on clock low, so im_instr is valid before the next rising edge) and the decode stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OP, 4'hF, opcode (instr[15:12]) that halts fetch.
- NOP_INSTR, 16'h0000, word placed in if_id_instr for bubbles.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- stall, input, 1, hazard unit hold request; freezes PC and IF/ID.
- flush, input, 1, branch/jump taken; redirect PC and squash IF/ID.
- br_tgt, input, 16, redirect target, sampled when flush=1.
- im_addr, output, 16, instruction memory address; equals pc combinationally.
- im_rd_en, output, 1, read enable to instruction memory.
- im_instr, input, 16, word returned by instruction memory this cycle.
- pc, output, 16, current fetch PC.
- if_id_instr, output, 16, registered fetched instruction.
- if_id_pc_plus1, output, 16, registered pc+1 of that instruction, used for branch/JAL.
- if_id_valid, output, 1, IF/ID holds a real instruction.
- halted, output, 1, fetch stopped on HLT.
- fetch_cnt, output, 16, count of instructions passed to IF/ID; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at posedge) values: pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus1=0, if_id_valid=0, fetch_cnt=0, state=RUN.
- Reset overrides all other inputs, including mid-stall, mid-flush and HALTED.
- States: RUN, HALTED. halted = (state==HALTED).
- im_rd_en = (state==RUN) & ~stall & ~rst, combinational. im_addr = pc always.
- Input priority at each posedge: rst > flush > stall > HLT detect > normal advance.
- Flush, any state (overrides stall):
  - pc <= br_tgt.
  - if_id_instr <= NOP_INSTR, if_id_valid <= 0.
  - state <= RUN; a speculatively fetched HLT is cancelled.
  - fetch_cnt unchanged.
- Stall (no flush): pc, IF/ID registers, state and fetch_cnt all hold.
- RUN, normal (no stall, no flush), im_instr[15:12] != HLT_OP:
  - if_id_instr <= im_instr, if_id_pc_plus1 <= pc+1, if_id_valid <= 1.
  - pc <= pc+1, wrapping modulo 2^16 (16'hFFFF -> 16'h0000).
  - fetch_cnt++.
- RUN, normal, im_instr[15:12] == HLT_OP:
  - IF/ID loads the HLT with valid=1; fetch_cnt++.
  - pc holds at the HLT address.
  - state <= HALTED.
- HALTED, no stall, no flush: if_id_instr <= NOP_INSTR, if_id_valid <= 0; pc holds.
- HALTED with stall: IF/ID holds, so the HLT stays in decode.
- Latency: the word at address A appears in if_id_instr on the rising edge ending the cycle in which pc==A and im_rd_en=1. Throughput is 1 instruction/cycle.
- fetch_cnt saturates: no wrap past 16'hFFFF.
- im_instr is ignored whenever im_rd_en=0.

Test Plan:
- Reset, then memory holds 0x1111, 0x2222, 0x3333 at 0..2 -> if_id_instr = 0x1111, 0x2222, 0x3333 on consecutive edges; if_id_pc_plus1 = 1, 2, 3; fetch_cnt = 3; im_rd_en=1 throughout.
- Stall for 2 cycles while pc=5 -> pc stays 5, im_rd_en=0, IF/ID unchanged, fetch_cnt unchanged; sequential fetch resumes at 5.
- flush=1 with br_tgt=0x0040 while stall=1 -> next cycle pc=0x0040, if_id_valid=0, if_id_instr=NOP_INSTR; next fetched word comes from address 0x40.
- HLT: mem[3]=0xF000 -> IF/ID=0xF000 with valid=1, halted=1, pc stays 3, im_rd_en=0. The following cycle valid=0; stays halted indefinitely. A subsequent flush with br_tgt=0x10 -> halted=0, fetch resumes at 0x10.
- PC wrap: flush to 0xFFFF with a non-HLT word there -> if_id_pc_plus1=0x0000, pc=0x0000.
- rst asserted mid-stream while stall=1 and state=HALTED -> next edge: pc=RESET_PC, if_id_valid=0, fetch_cnt=0, halted=0.
